shutter_seq_core: RTL and testbench

SHUTTER_SEQ_CORE -- requirements
Module: shutter_seq_core

---
 rtl/shutter_seq_pkg.sv | 23 ++
 rtl/shutter_seq_core_timer.sv | 28 ++
 rtl/shutter_seq_core.sv | 240 ++++++++++++++++++++++++
 tb/tb_shutter_seq_core.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/shutter_seq_pkg.sv
// Shared definitions for the shutter sequencer: FSM encoding, test-pulse
// phase encoding and default counter widths.
package shutter_seq_pkg;

    localparam int DEF_CNT_WIDTH = 32;
    localparam int DEF_REP_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        T0    = 3'd1,
        DELAY = 3'd2,
        OPEN  = 3'd3,
        GAP   = 3'd4
    } seq_state_t;

    // Phases of the optional test pulse inside one OPEN window.
    typedef enum logic [1:0] {
        TP_OFF  = 2'd0,
        TP_WAIT = 2'd1,
        TP_ON   = 2'd2
    } tp_phase_t;

endpackage

// File: rtl/shutter_seq_core_timer.sv
// seq_timer: loadable down-counter with enable and zero flag. The counter
// parks at zero, so it never wraps.
module seq_timer #(
    parameter int W = 32
) (
    input  logic         BUS_CLK,
    input  logic         BUS_RST,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load wins over counting; counting stops at zero.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/shutter_seq_core.sv
// shutter_seq_core: T0 / delay / shutter-open / gap sequencer with frame
// counting, abort and optional external test pulse.
// Optional feature macro: SHUTTER_SEQ_TPULSE_EN (compiles in the test-pulse
// generator; without it EXT_TPULSE is tied low).
// Timers are loaded with (duration-1) on state entry and the state is left
// in the cycle the timer reads zero, so a state lasts exactly its duration.
module shutter_seq_core
    import shutter_seq_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int REP_WIDTH = DEF_REP_WIDTH
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic                 START,
    input  logic                 STOP,
    input  logic                 T0_EN,
    input  logic [7:0]           T0_WIDTH,
    input  logic [CNT_WIDTH-1:0] SHUTTER_DELAY,
    input  logic [CNT_WIDTH-1:0] SHUTTER_WIDTH,
    input  logic [CNT_WIDTH-1:0] SHUTTER_GAP,
    input  logic [REP_WIDTH-1:0] REPEAT,
    input  logic [15:0]          TP_DELAY,
    input  logic [15:0]          TP_WIDTH,
    output logic                 T0_SYNC,
    output logic                 SHUTTER,
    output logic                 EXT_TPULSE,
    output logic                 SHUTTER_RISE,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ABORTED,
    output logic [REP_WIDTH-1:0] FRAME_CNT
);

    seq_state_t state, nxt;

    logic [CNT_WIDTH-1:0] sh_delay, sh_width, sh_gap;
    logic [REP_WIDTH-1:0] sh_rep;
    logic [REP_WIDTH-1:0] frame_inc;

    logic                 tmr_load, tmr_zero, tmr_en;
    logic [CNT_WIDTH-1:0] tmr_val;
    logic                 start_acc, frame_done, seq_end, abort;

    // Zero-length durations behave as one cycle.
    function automatic logic [CNT_WIDTH-1:0] dur_m1(input logic [CNT_WIDTH-1:0] x);
        return (x == '0) ? '0 : x - 1'b1;
    endfunction

    // START together with STOP in IDLE is treated as no request at all.
    assign start_acc = (state == IDLE) && START && !STOP;
    assign frame_inc = FRAME_CNT + 1'b1;
    assign tmr_en    = (state != IDLE);

    seq_timer #(.W(CNT_WIDTH)) u_state_tmr (
        .BUS_CLK  (BUS_CLK),
        .BUS_RST  (BUS_RST),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Next-state and timer-load decode. Leaving IDLE uses the live config
    // inputs because the shadow copies are only written on that same edge.
    always_comb begin
        nxt        = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        frame_done = 1'b0;
        seq_end    = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: if (start_acc) begin
                tmr_load = 1'b1;
                if (T0_EN) begin
                    nxt     = T0;
                    tmr_val = dur_m1(CNT_WIDTH'(T0_WIDTH));
                end else if (SHUTTER_DELAY != '0) begin
                    nxt     = DELAY;
                    tmr_val = SHUTTER_DELAY - 1'b1;
                end else begin
                    nxt     = OPEN;
                    tmr_val = dur_m1(SHUTTER_WIDTH);
                end
            end
            T0: if (tmr_zero) begin
                tmr_load = 1'b1;
                if (sh_delay != '0) begin
                    nxt     = DELAY;
                    tmr_val = sh_delay - 1'b1;
                end else begin
                    nxt     = OPEN;
                    tmr_val = dur_m1(sh_width);
                end
            end
            DELAY: if (tmr_zero) begin
                nxt      = OPEN;
                tmr_load = 1'b1;
                tmr_val  = dur_m1(sh_width);
            end
            OPEN: if (tmr_zero) begin
                frame_done = 1'b1;
                if (sh_rep != '0 && frame_inc == sh_rep) begin
                    nxt     = IDLE;
                    seq_end = 1'b1;
                end else begin
                    nxt      = GAP;
                    tmr_load = 1'b1;
                    tmr_val  = dur_m1(sh_gap);
                end
            end
            GAP: if (tmr_zero) begin
                nxt      = OPEN;
                tmr_load = 1'b1;
                tmr_val  = dur_m1(sh_width);
            end
            default: nxt = IDLE;
        endcase
        // Abort overrides any transition; a frame ending on this very cycle
        // still counts since its shutter window was complete.
        if (STOP && state != IDLE) begin
            nxt      = IDLE;
            abort    = 1'b1;
            tmr_load = 1'b0;
            seq_end  = 1'b0;
        end
    end

    // State, shadow config and registered outputs derived from next state.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state        <= IDLE;
            sh_delay     <= '0;
            sh_width     <= '0;
            sh_gap       <= '0;
            sh_rep       <= '0;
            T0_SYNC      <= 1'b0;
            SHUTTER      <= 1'b0;
            SHUTTER_RISE <= 1'b0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            ABORTED      <= 1'b0;
            FRAME_CNT    <= '0;
        end else begin
            state        <= nxt;
            T0_SYNC      <= (nxt == T0);
            SHUTTER      <= (nxt == OPEN);
            SHUTTER_RISE <= (nxt == OPEN) && (state != OPEN);
            BUSY         <= (nxt != IDLE);
            DONE         <= seq_end || abort;
            if (start_acc) begin
                sh_delay  <= SHUTTER_DELAY;
                sh_width  <= SHUTTER_WIDTH;
                sh_gap    <= SHUTTER_GAP;
                sh_rep    <= REPEAT;
                FRAME_CNT <= '0;
                ABORTED   <= 1'b0;
            end else begin
                if (frame_done && FRAME_CNT != '1)
                    FRAME_CNT <= frame_inc;
                if (abort)
                    ABORTED <= 1'b1;
            end
        end
    end

`ifdef SHUTTER_SEQ_TPULSE_EN
    logic [15:0] sh_tp_delay, sh_tp_width, tpd, tpw, tp_val;
    logic        tp_load, tp_zero, open_entry, open_stay;
    tp_phase_t   tp_phase;

    assign open_entry = (nxt == OPEN) && (state != OPEN);
    assign open_stay  = (nxt == OPEN) && (state == OPEN);
    // Entry straight from IDLE has not captured the shadows yet.
    assign tpd = (state == IDLE) ? TP_DELAY : sh_tp_delay;
    assign tpw = (state == IDLE) ? TP_WIDTH : sh_tp_width;

    seq_timer #(.W(16)) u_tp_tmr (
        .BUS_CLK  (BUS_CLK),
        .BUS_RST  (BUS_RST),
        .load     (tp_load),
        .en       (state == OPEN),
        .load_val (tp_val),
        .zero     (tp_zero)
    );

    // Test-pulse timer loads: delay on shutter rise, width when pulse starts.
    always_comb begin
        tp_load = 1'b0;
        tp_val  = '0;
        if (open_entry && tpw != '0) begin
            tp_load = 1'b1;
            tp_val  = (tpd != '0) ? tpd - 1'b1 : tpw - 1'b1;
        end else if (open_stay && tp_phase == TP_WAIT && tp_zero) begin
            tp_load = 1'b1;
            tp_val  = tpw - 1'b1;
        end
    end

    // Test-pulse phase and output; forced low whenever the shutter closes.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            tp_phase    <= TP_OFF;
            EXT_TPULSE  <= 1'b0;
            sh_tp_delay <= '0;
            sh_tp_width <= '0;
        end else begin
            if (start_acc) begin
                sh_tp_delay <= TP_DELAY;
                sh_tp_width <= TP_WIDTH;
            end
            if (open_entry) begin
                if (tpw == '0) begin
                    tp_phase <= TP_OFF;  EXT_TPULSE <= 1'b0;
                end else if (tpd == '0) begin
                    tp_phase <= TP_ON;   EXT_TPULSE <= 1'b1;
                end else begin
                    tp_phase <= TP_WAIT; EXT_TPULSE <= 1'b0;
                end
            end else if (open_stay) begin
                if (tp_phase == TP_WAIT && tp_zero) begin
                    tp_phase <= TP_ON;  EXT_TPULSE <= 1'b1;
                end else if (tp_phase == TP_ON && tp_zero) begin
                    tp_phase <= TP_OFF; EXT_TPULSE <= 1'b0;
                end
            end else begin
                tp_phase   <= TP_OFF;
                EXT_TPULSE <= 1'b0;
            end
        end
    end
`else
    // Test-pulse inputs are deliberately left dangling in this build.
    logic tp_inputs_unused;
    assign tp_inputs_unused = ^{TP_DELAY, TP_WIDTH};
    assign EXT_TPULSE = 1'b0;
`endif

endmodule

// File: tb/tb_shutter_seq_core.sv
// Bench for shutter_seq_core: a cycle-level timing model fills a scoreboard
// queue when each sequence is launched; the queue is drained one entry per
// cycle against the DUT outputs.
module tb_shutter_seq_core;

    logic        BUS_CLK = 1'b0;
    logic        BUS_RST, START, STOP, T0_EN;
    logic [7:0]  T0_WIDTH;
    logic [31:0] SHUTTER_DELAY, SHUTTER_WIDTH, SHUTTER_GAP;
    logic [15:0] REPEAT, TP_DELAY, TP_WIDTH;
    logic        T0_SYNC, SHUTTER, EXT_TPULSE, SHUTTER_RISE, BUSY, DONE, ABORTED;
    logic [15:0] FRAME_CNT;

    int total = 0;
    int bad   = 0;
    logic [22:0] sb[$];
    logic [22:0] obs;

`ifdef SHUTTER_SEQ_TPULSE_EN
    localparam bit TPEN = 1'b1;
`else
    localparam bit TPEN = 1'b0;
`endif

    shutter_seq_core dut (
        .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .START(START), .STOP(STOP),
        .T0_EN(T0_EN), .T0_WIDTH(T0_WIDTH), .SHUTTER_DELAY(SHUTTER_DELAY),
        .SHUTTER_WIDTH(SHUTTER_WIDTH), .SHUTTER_GAP(SHUTTER_GAP), .REPEAT(REPEAT),
        .TP_DELAY(TP_DELAY), .TP_WIDTH(TP_WIDTH), .T0_SYNC(T0_SYNC),
        .SHUTTER(SHUTTER), .EXT_TPULSE(EXT_TPULSE), .SHUTTER_RISE(SHUTTER_RISE),
        .BUSY(BUSY), .DONE(DONE), .ABORTED(ABORTED), .FRAME_CNT(FRAME_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    assign obs = {T0_SYNC, SHUTTER, EXT_TPULSE, SHUTTER_RISE, BUSY, DONE, ABORTED, FRAME_CNT};

    task automatic check_pop(input string name, input int cyc);
        logic [22:0] exp;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL %s cyc=%0d scoreboard empty", name, cyc);
            return;
        end
        exp = sb.pop_front();
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got t0/sh/tp/rise/busy/done/ab=%b fc=%0d exp=%b fc=%0d",
                     name, cyc, obs[22:16], obs[15:0], exp[22:16], exp[15:0]);
        end
    endtask

    // Timing model: expected outputs for cycles 1..n after a START in cycle 0.
    task automatic model(input bit t0en, input int t0w, input int d, input int w,
                         input int g, input int rep, input int tpd, input int tpw,
                         input int stopc, input int n);
        bit t0a[600], sha[600], tpa[600], ra[600], ba[600], da[600], aa[600], inc[600];
        int fa[600];
        int c, fc, wm, gm, tm, f;
        bit fin;
        for (int i = 0; i < 600; i++) begin
            t0a[i] = 0; sha[i] = 0; tpa[i] = 0; ra[i] = 0; ba[i] = 0;
            da[i] = 0; aa[i] = 0; inc[i] = 0; fa[i] = 0;
        end
        wm = (w == 0) ? 1 : w;
        gm = (g == 0) ? 1 : g;
        tm = (t0w == 0) ? 1 : t0w;
        c = 1; fc = 0; fin = 0;
        if (t0en) for (int k = 0; k < tm; k++) begin t0a[c] = 1; ba[c] = 1; c++; end
        for (int k = 0; k < d; k++) begin ba[c] = 1; c++; end
        while (!fin && c <= n) begin
            for (int k = 0; k < wm; k++) begin
                sha[c] = 1; ba[c] = 1; ra[c] = (k == 0);
                tpa[c] = TPEN && tpw != 0 && k >= tpd && k < tpd + tpw;
                c++;
            end
            fc++; inc[c] = 1;
            if (rep != 0 && fc == rep) begin
                da[c] = 1; fin = 1;
            end else begin
                for (int k = 0; k < gm; k++) begin ba[c] = 1; c++; end
            end
        end
        f = 0;
        for (int i = 1; i <= n; i++) begin
            if (inc[i]) f++;
            fa[i] = f;
        end
        if (stopc > 0 && ba[stopc]) begin
            for (int i = stopc + 1; i <= n; i++) begin
                t0a[i] = 0; sha[i] = 0; tpa[i] = 0; ra[i] = 0; ba[i] = 0; da[i] = 0;
                aa[i] = 1; fa[i] = fa[stopc];
            end
            da[stopc + 1] = 1;
        end
        for (int i = 1; i <= n; i++)
            sb.push_back({t0a[i], sha[i], tpa[i], ra[i], ba[i], da[i], aa[i], 16'(fa[i])});
    endtask

    // Launch one sequence, scramble the config after START, drain n cycles.
    task automatic run(input string name, input bit t0en, input int t0w, input int d,
                       input int w, input int g, input int rep, input int tpd,
                       input int tpw, input int stopc, input int restart_c, input int n);
        model(t0en, t0w, d, w, g, rep, tpd, tpw, stopc, n);
        T0_EN = t0en; T0_WIDTH = 8'(t0w); SHUTTER_DELAY = 32'(d);
        SHUTTER_WIDTH = 32'(w); SHUTTER_GAP = 32'(g); REPEAT = 16'(rep);
        TP_DELAY = 16'(tpd); TP_WIDTH = 16'(tpw);
        START = 1'b1;
        @(posedge BUS_CLK); #1;
        START = 1'b0;
        T0_EN = ~t0en; T0_WIDTH = 8'd9; SHUTTER_DELAY = 32'd3; SHUTTER_WIDTH = 32'd2;
        SHUTTER_GAP = 32'd7; REPEAT = 16'd5; TP_DELAY = 16'd0; TP_WIDTH = 16'd1;
        for (int c = 1; c <= n; c++) begin
            check_pop(name, c);
            STOP  = (c == stopc);
            START = (c == restart_c);
            @(posedge BUS_CLK); #1;
        end
        START = 1'b0; STOP = 1'b0;
    endtask

    task automatic test_reset();
        BUS_RST = 1'b1; START = 1'b1; STOP = 1'b1;
        repeat (2) @(posedge BUS_CLK);
        #1;
        sb.push_back(23'd0);
        check_pop("reset", 0);
        BUS_RST = 1'b0; START = 1'b0; STOP = 1'b0;
        @(posedge BUS_CLK); #1;
    endtask

    task automatic test_t0_single();
        run("t0_single", 1, 4, 10, 100, 0, 1, 0, 0, -1, -1, 120);
    endtask

    task automatic test_multi_frame();
        run("multi_frame", 0, 0, 0, 5, 3, 3, 0, 0, -1, 3, 26);
    endtask

    task automatic test_stop();
        run("stop", 0, 0, 0, 20, 5, 0, 0, 0, 40, -1, 45);
    endtask

    // START+STOP together in IDLE: nothing changes (ABORTED/FRAME_CNT kept).
    task automatic test_start_stop_same();
        START = 1'b1; STOP = 1'b1;
        @(posedge BUS_CLK); #1;
        START = 1'b0; STOP = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            sb.push_back({7'b0000001, 16'd1});
            check_pop("start_stop_same", c);
            @(posedge BUS_CLK); #1;
        end
    endtask

    task automatic test_min_values();
        run("min_values", 1, 0, 0, 0, 0, 2, 0, 0, -1, -1, 8);
    endtask

    task automatic test_tpulse();
        run("tpulse_trunc", 0, 0, 2, 10, 4, 2, 8, 5, -1, -1, 30);
        run("tpulse_d0",    0, 0, 0, 6, 2, 1, 0, 3, -1, -1, 10);
        run("tpulse_w0",    0, 0, 0, 6, 2, 1, 2, 0, -1, -1, 10);
    endtask

    // Reset during an open shutter: everything low next cycle, no DONE.
    task automatic test_reset_mid();
        T0_EN = 1'b0; T0_WIDTH = 8'd0; SHUTTER_DELAY = 32'd0; SHUTTER_WIDTH = 32'd100;
        SHUTTER_GAP = 32'd1; REPEAT = 16'd1; TP_DELAY = 16'd0; TP_WIDTH = 16'd0;
        START = 1'b1;
        @(posedge BUS_CLK); #1;
        START = 1'b0;
        repeat (49) @(posedge BUS_CLK);
        #1;
        sb.push_back({7'b0100100, 16'd0});
        check_pop("reset_mid_open", 50);
        BUS_RST = 1'b1;
        @(posedge BUS_CLK); #1;
        sb.push_back(23'd0);
        check_pop("reset_mid_after", 51);
        BUS_RST = 1'b0;
        @(posedge BUS_CLK); #1;
        sb.push_back(23'd0);
        check_pop("reset_mid_nodone", 52);
    endtask

    initial begin
        BUS_RST = 1'b0; START = 1'b0; STOP = 1'b0; T0_EN = 1'b0; T0_WIDTH = '0;
        SHUTTER_DELAY = '0; SHUTTER_WIDTH = '0; SHUTTER_GAP = '0; REPEAT = '0;
        TP_DELAY = '0; TP_WIDTH = '0;
        test_reset();
        test_t0_single();
        test_multi_frame();
        test_stop();
        test_start_stop_same();
        test_min_values();
        test_tpulse();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
